aud_recorder: RTL and testbench
===============================

# aud_recorder

Capture stage upstream of the playback DSP. Samples the WM8731 I2S ADC stream (BCLK/ADCLRCK/ADCDAT) in the system clock domain and deserialises one channel into 16-bit words. Writes each word to consecutive SRAM addresses starting at 0. On stop or full, publishes the exclusive end address that the playback DSP consumes as its final address.

## Interface
- DATA_W, 16, sample width
- ADDR_W, 20, SRAM address width
- DEPTH, 20'hFFFFF, max words recorded (≤ 2^ADDR_W − 1)
- CAP_LRC, 1'b0, LRC level of the captured channel
- WE_CYCLES, 2, cycles o_sram_we_n held low per write (≥1)
- i_clk  in  1  system clock; all logic on posedge
- i_rst_n  in  1  asynchronous active-low reset
- i_bclk  in  1  codec bit clock (asynchronous, sampled)
- i_lrc  in  1  codec ADCLRCK (asynchronous, sampled)
- i_adc_dat  in  1  codec ADCDAT (asynchronous, sampled)
- i_start  in  1  start new recording (IDLE) / resume (PAUSE), one-cycle pulse
- i_pause  in  1  pause, one-cycle pulse
- i_stop  in  1  stop, one-cycle pulse
- o_sram_addr  out  ADDR_W  write address
- o_sram_data  out  DATA_W  write data
- o_sram_we_n  out  1  active-low write strobe
- o_final_address  out  ADDR_W  words recorded (exclusive end address)
- o_recording  out  1  high in WAIT/SKIP/SHIFT/WRITE
- o_full  out  1  DEPTH reached; sticky until next start from IDLE

## Operation
- i_bclk, i_lrc, i_adc_dat pass through 2-flop synchronisers. bclk_rise = synced bclk 0→1. All codec events act only on bclk_rise.
- States: IDLE, WAIT, SKIP, SHIFT, WRITE, PAUSE.
- IDLE: on i_start, addr←0, o_full←0, o_final_address←0, go WAIT.
- WAIT: on bclk_rise where synced lrc == CAP_LRC and previous sampled lrc != CAP_LRC (channel start), go SKIP.
- SKIP: I2S one-bit delay. Ignore the next bclk_rise, then go SHIFT with bit count 0.
- SHIFT: on each bclk_rise, shift ← {shift[DATA_W-2:0], adc_dat}, MSB first. After DATA_W bits, latch o_sram_data and go WRITE.
- WRITE: o_sram_we_n low for WE_CYCLES cycles with o_sram_addr/o_sram_data stable. On the cycle after release, addr += 1 and o_final_address ← addr+1.
  - If addr+1 == DEPTH: o_full←1, go IDLE.
  - Else go WAIT.
- PAUSE: no codec activity. i_start goes to WAIT with address retained.
- Priority per cycle: i_stop > i_pause > i_start.
- i_stop in any non-IDLE state: go IDLE. o_final_address keeps the count of completed writes.
- i_pause in WAIT/SKIP/SHIFT: go PAUSE.
- i_stop or i_pause during WRITE: the write completes first (strobe never truncated). The address increments, then the block goes IDLE or PAUSE.
- Partial words (stop/pause in SKIP/SHIFT) are discarded and never written.
- i_start ignored in WAIT/SKIP/SHIFT/WRITE. i_pause and i_stop ignored in IDLE. i_pause ignored in PAUSE.

## Timing
- Reset (async assert, sync release): state IDLE, o_sram_addr 0, o_sram_data 0, o_sram_we_n 1, o_final_address 0, o_recording 0, o_full 0.
- Reset asserted mid-WRITE: we_n rises immediately, asynchronously.
- Pin-to-bclk_rise latency is 3 i_clk cycles. Requires f(i_clk) ≥ 4·f(bclk).
- o_sram_data changes only on entry to WRITE. Address and data are valid ≥1 cycle before we_n falls and are held until the cycle after we_n rises.
- we_n falls the cycle after the last data bit's bclk_rise.
- o_final_address updates the same cycle addr increments.
- A full frame (≥2·DATA_W+2 bclk) leaves WRITE slack. The next channel start is never missed at the minimum clock ratio.

## Structure
- Package aud_pkg: state enum (rec_state_t), CAP_LEFT/CAP_RIGHT constants, default ADDR_W/DATA_W localparams shared with the playback DSP.
- Sub-module aud_i2s_sync: 3-bit 2-flop synchroniser plus bclk rising-edge pulse and delayed lrc. Reset follows i_rst_n.
- Top: FSM, bit counter (log2(DATA_W)+1 bits), WE_CYCLES counter, shift register, address/final registers.

## Test plan
- Start, one I2S frame with captured channel 16'hA5C3 and other channel 16'hFFFF: single write of 16'hA5C3 at addr 0, we_n low 2 cycles, o_final_address=1.
- Start, 3 frames (16'h0001, 16'h8000, 16'h7FFF), stop: writes at 0,1,2 with exact data, o_final_address=3, o_recording=0.
- Start, 2 frames, pause, 5 idle frames, i_start, 2 frames: writes contiguous at addrs 0–3, nothing written during pause.
- DEPTH=4: 6 frames: 4 writes, o_full=1 after 4th, o_final_address=4, frames 5–6 produce no we_n pulse.
- Stop at bit 8 of the 3rd word: only 2 writes, o_final_address=2. Stop asserted in the first WRITE cycle: that write completes, o_final_address=1.
- Reset pulled low during WRITE: we_n=1 and all outputs at reset values immediately. After release, next i_start begins at addr 0.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared definitions for the audio capture path and the playback DSP.
`timescale 1ns/1ps
package aud_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SKIP,
        ST_SHIFT,
        ST_WRITE,
        ST_PAUSE
    } rec_state_t;

    // LRC level that marks each codec channel
    localparam logic CAP_LEFT  = 1'b0;
    localparam logic CAP_RIGHT = 1'b1;

    localparam int AUD_ADDR_W = 20;
    localparam int AUD_DATA_W = 16;
endpackage

// File: rtl/aud_recorder_if.sv
// SRAM write bus between the recorder (master) and the sample memory (slave).
`timescale 1ns/1ps
interface aud_recorder_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] o_sram_addr;
    logic [DATA_W-1:0] o_sram_data;
    logic              o_sram_we_n;

    modport master (output o_sram_addr, output o_sram_data, output o_sram_we_n);
    modport slave  (input  o_sram_addr, input  o_sram_data, input  o_sram_we_n);
endinterface

// File: rtl/aud_i2s_sync.sv
// Brings the asynchronous codec pins into the system clock domain and
// flags bit-clock rising edges; also keeps the lrc seen at the previous edge.
`timescale 1ns/1ps
module aud_i2s_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic bclk_pin,
    input  logic lrc_pin,
    input  logic dat_pin,
    output logic bclk_rise,
    output logic lrc,
    output logic lrc_prev,
    output logic dat
);
    logic [2:0] meta;
    logic [2:0] sync;
    logic       bclk_d;

    // two-flop synchroniser, edge-detect delay, and lrc history per bclk edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta     <= '0;
            sync     <= '0;
            bclk_d   <= 1'b0;
            lrc_prev <= 1'b0;
        end else begin
            meta   <= {bclk_pin, lrc_pin, dat_pin};
            sync   <= meta;
            bclk_d <= sync[2];
            if (sync[2] && !bclk_d)
                lrc_prev <= sync[1];
        end
    end

    assign bclk_rise = sync[2] & ~bclk_d;
    assign lrc       = sync[1];
    assign dat       = sync[0];
endmodule

// File: rtl/aud_recorder.sv
// I2S single-channel capture into SRAM; publishes the exclusive end address.
`timescale 1ns/1ps
module aud_recorder
    import aud_pkg::*;
#(
    parameter int                DATA_W    = AUD_DATA_W,
    parameter int                ADDR_W    = AUD_ADDR_W,
    parameter logic [ADDR_W-1:0] DEPTH     = '1,
    parameter logic              CAP_LRC   = CAP_LEFT,
    parameter int                WE_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_bclk,
    input  logic              i_lrc,
    input  logic              i_adc_dat,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    aud_recorder_if.master    sram,
    output logic [ADDR_W-1:0] o_final_address,
    output logic              o_recording,
    output logic              o_full
);
    localparam int CNT_W  = $clog2(DATA_W) + 1;
    localparam int WCNT_W = $clog2(WE_CYCLES + 2);

    rec_state_t        state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we_n;
    logic [DATA_W-2:0] shift;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WCNT_W-1:0] we_cnt;
    logic              stop_pend;
    logic              pause_pend;
    logic              bclk_rise;
    logic              lrc;
    logic              lrc_prev;
    logic              dat;
    logic [ADDR_W-1:0] addr_nxt;

    aud_i2s_sync u_sync (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .bclk_pin  (i_bclk),
        .lrc_pin   (i_lrc),
        .dat_pin   (i_adc_dat),
        .bclk_rise (bclk_rise),
        .lrc       (lrc),
        .lrc_prev  (lrc_prev),
        .dat       (dat)
    );

    assign addr_nxt         = addr + 1'b1;
    assign sram.o_sram_addr = addr;
    assign sram.o_sram_data = data;
    assign sram.o_sram_we_n = we_n;

    // recorder FSM; a write in progress always runs to completion and
    // remembers any stop/pause seen meanwhile
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            addr            <= '0;
            data            <= '0;
            we_n            <= 1'b1;
            shift           <= '0;
            bit_cnt         <= '0;
            we_cnt          <= '0;
            stop_pend       <= 1'b0;
            pause_pend      <= 1'b0;
            o_final_address <= '0;
            o_recording     <= 1'b0;
            o_full          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        addr            <= '0;
                        o_full          <= 1'b0;
                        o_final_address <= '0;
                        o_recording     <= 1'b1;
                        state           <= ST_WAIT;
                    end
                end
                ST_WAIT, ST_SKIP, ST_SHIFT: begin
                    if (i_stop) begin
                        o_recording <= 1'b0;
                        state       <= ST_IDLE;
                    end else if (i_pause) begin
                        o_recording <= 1'b0;
                        state       <= ST_PAUSE;
                    end else if (bclk_rise) begin
                        if (state == ST_WAIT) begin
                            if (lrc == CAP_LRC && lrc_prev != CAP_LRC)
                                state <= ST_SKIP;
                        end else if (state == ST_SKIP) begin
                            bit_cnt <= '0;
                            state   <= ST_SHIFT;
                        end else begin
                            shift <= {shift[DATA_W-3:0], dat};
                            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                                data       <= {shift, dat};
                                we_cnt     <= '0;
                                stop_pend  <= 1'b0;
                                pause_pend <= 1'b0;
                                state      <= ST_WRITE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    stop_pend  <= stop_pend | i_stop;
                    pause_pend <= pause_pend | i_pause;
                    we_cnt     <= we_cnt + 1'b1;
                    if (we_cnt == '0)
                        we_n <= 1'b0;
                    if (we_cnt == WCNT_W'(WE_CYCLES))
                        we_n <= 1'b1;
                    if (we_cnt == WCNT_W'(WE_CYCLES + 1)) begin
                        addr            <= addr_nxt;
                        o_final_address <= addr_nxt;
                        if (addr_nxt == DEPTH) begin
                            o_full      <= 1'b1;
                            o_recording <= 1'b0;
                            state       <= ST_IDLE;
                        end else if (stop_pend || i_stop) begin
                            o_recording <= 1'b0;
                            state       <= ST_IDLE;
                        end else if (pause_pend || i_pause) begin
                            o_recording <= 1'b0;
                            state       <= ST_PAUSE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (i_stop) begin
                        state <= ST_IDLE;
                    end else if (i_start) begin
                        o_recording <= 1'b1;
                        state       <= ST_WAIT;
                    end
                end
                default: begin
                    o_recording <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aud_recorder.sv
// Directed bench for aud_recorder: I2S frames driven on the pins, SRAM writes
// captured by a monitor, expectations hand-computed per step.
`timescale 1ns/1ps
module tb_aud_recorder;
    import aud_pkg::*;

    logic i_clk = 1'b0, i_rst_n = 1'b0;
    logic i_bclk = 1'b0, i_lrc = 1'b1, i_adc_dat = 1'b0;
    logic i_start = 1'b0, i_pause = 1'b0, i_stop = 1'b0;
    logic i_start4 = 1'b0, i_pause4 = 1'b0, i_stop4 = 1'b0;
    logic [19:0] final_addr, final_addr4;
    logic        rec, rec4, full, full4;
    int tests = 0, fails = 0;

    aud_recorder_if #(.ADDR_W(20), .DATA_W(16)) sram_bus ();
    aud_recorder_if #(.ADDR_W(20), .DATA_W(16)) sram4_bus ();

    always #5 i_clk = ~i_clk;

    aud_recorder #(.DATA_W(16), .ADDR_W(20), .DEPTH(20'hFFFFF), .CAP_LRC(1'b0), .WE_CYCLES(2)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_bclk(i_bclk), .i_lrc(i_lrc), .i_adc_dat(i_adc_dat),
        .i_start(i_start), .i_pause(i_pause), .i_stop(i_stop), .sram(sram_bus),
        .o_final_address(final_addr), .o_recording(rec), .o_full(full));

    aud_recorder #(.DATA_W(16), .ADDR_W(20), .DEPTH(20'd4), .CAP_LRC(1'b0), .WE_CYCLES(2)) dut4 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_bclk(i_bclk), .i_lrc(i_lrc), .i_adc_dat(i_adc_dat),
        .i_start(i_start4), .i_pause(i_pause4), .i_stop(i_stop4), .sram(sram4_bus),
        .o_final_address(final_addr4), .o_recording(rec4), .o_full(full4));

    // write monitors: one entry per we_n pulse, with its low-cycle length
    logic [19:0] wa[$];
    logic [15:0] wd[$];
    int          wl[$];
    logic [19:0] wa4[$];
    int          stab_err = 0;
    logic        prev_we = 1'b1, prev_we4 = 1'b1;

    always @(negedge i_clk) begin
        if (!sram_bus.o_sram_we_n) begin
            if (prev_we) begin
                wa.push_back(sram_bus.o_sram_addr);
                wd.push_back(sram_bus.o_sram_data);
                wl.push_back(1);
            end else begin
                wl[wl.size()-1] = wl[wl.size()-1] + 1;
                if (sram_bus.o_sram_addr != wa[wa.size()-1] || sram_bus.o_sram_data != wd[wd.size()-1])
                    stab_err = stab_err + 1;
            end
        end
        prev_we = sram_bus.o_sram_we_n;
        if (!sram4_bus.o_sram_we_n && prev_we4)
            wa4.push_back(sram4_bus.o_sram_addr);
        prev_we4 = sram4_bus.o_sram_we_n;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] qa(input int i);
        return (i < wa.size()) ? {12'h0, wa[i]} : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] qd(input int i);
        return (i < wd.size()) ? {16'h0, wd[i]} : 32'hxxxxxxxx;
    endfunction
    function automatic logic [31:0] ql(input int i);
        return (i < wl.size()) ? wl[i] : 32'hxxxxxxxx;
    endfunction

    task automatic clear_q();
        wa.delete(); wd.delete(); wl.delete(); wa4.delete();
    endtask

    task automatic pulse_start();  @(negedge i_clk); i_start = 1;  @(negedge i_clk); i_start = 0;  endtask
    task automatic pulse_pause();  @(negedge i_clk); i_pause = 1;  @(negedge i_clk); i_pause = 0;  endtask
    task automatic pulse_stop();   @(negedge i_clk); i_stop = 1;   @(negedge i_clk); i_stop = 0;   endtask
    task automatic pulse_start4(); @(negedge i_clk); i_start4 = 1; @(negedge i_clk); i_start4 = 0; endtask
    task automatic pulse_stop4();  @(negedge i_clk); i_stop4 = 1;  @(negedge i_clk); i_stop4 = 0;  endtask

    // one bclk period: lrc/dat change on the falling edge, sampled on the rise
    task automatic slot(input logic d, input logic l);
        i_bclk = 0; i_lrc = l; i_adc_dat = d; #40;
        i_bclk = 1; #40;
    endtask

    // slot 0 = channel start, slot 1 = skipped delay bit, slots 2..17 = MSB..LSB
    function automatic logic bitv(input logic [15:0] w, input int k);
        return (k >= 2 && k <= 17) ? w[17-k] : 1'b0;
    endfunction

    // other channel (lrc=1) first, then captured channel (lrc=0); optional stop before slot stop_at
    task automatic frame(input logic [15:0] cap, input logic [15:0] oth, input int stop_at);
        for (int k = 0; k < 20; k++) slot(bitv(oth, k), 1'b1);
        for (int k = 0; k < 20; k++) begin
            if (k == stop_at) pulse_stop();
            slot(bitv(cap, k), 1'b0);
        end
        repeat (5) @(negedge i_clk);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge i_clk);
        chk("rst_we_n", sram_bus.o_sram_we_n, 1'b1);
        chk("rst_addr", sram_bus.o_sram_addr, 20'h0);
        chk("rst_data", sram_bus.o_sram_data, 16'h0);
        chk("rst_final", final_addr, 20'h0);
        chk("rst_rec_full", {rec, full}, 2'b00);
        i_rst_n = 1;
        repeat (2) @(negedge i_clk);

        // single frame
        pulse_start();
        chk("t1_rec_on", rec, 1'b1);
        frame(16'hA5C3, 16'hFFFF, -1);
        chk("t1_nwr", wa.size(), 1);
        chk("t1_addr", qa(0), 32'h0);
        chk("t1_data", qd(0), 32'hA5C3);
        chk("t1_we_len", ql(0), 32'd2);
        chk("t1_final", final_addr, 20'd1);
        chk("t1_addr_after", sram_bus.o_sram_addr, 20'd1);
        pulse_stop();
        chk("t1_rec_off", rec, 1'b0);

        // three frames then stop
        clear_q();
        pulse_start();
        chk("t2_final_cleared", final_addr, 20'd0);
        frame(16'h0001, 16'h1234, -1);
        frame(16'h8000, 16'hFFFF, -1);
        frame(16'h7FFF, 16'h0000, -1);
        pulse_stop();
        chk("t2_nwr", wa.size(), 3);
        chk("t2_a0", qa(0), 32'd0); chk("t2_d0", qd(0), 32'h0001);
        chk("t2_a1", qa(1), 32'd1); chk("t2_d1", qd(1), 32'h8000);
        chk("t2_a2", qa(2), 32'd2); chk("t2_d2", qd(2), 32'h7FFF);
        chk("t2_final", final_addr, 20'd3);
        chk("t2_rec", rec, 1'b0);

        // pause / resume
        clear_q();
        pulse_start();
        frame(16'h1111, 16'hAAAA, -1);
        frame(16'h2222, 16'hAAAA, -1);
        pulse_pause();
        chk("t3_rec_paused", rec, 1'b0);
        for (int i = 0; i < 5; i++) frame(16'h3333, 16'h5555, -1);
        chk("t3_nwr_paused", wa.size(), 2);
        pulse_start();
        chk("t3_rec_resumed", rec, 1'b1);
        frame(16'h4444, 16'hAAAA, -1);
        frame(16'h5555, 16'hAAAA, -1);
        chk("t3_nwr", wa.size(), 4);
        chk("t3_a2", qa(2), 32'd2); chk("t3_d2", qd(2), 32'h4444);
        chk("t3_a3", qa(3), 32'd3); chk("t3_d3", qd(3), 32'h5555);
        chk("t3_d1", qd(1), 32'h2222);
        chk("t3_final", final_addr, 20'd4);
        pulse_stop();

        // DEPTH=4 instance fills up
        clear_q();
        pulse_start4();
        for (int i = 0; i < 6; i++) begin
            frame(16'hA001 + 16'(i), 16'h0F0F, -1);
            if (i == 2) chk("t4_not_full_yet", full4, 1'b0);
        end
        chk("t4_nwr", wa4.size(), 4);
        chk("t4_last_addr", (wa4.size() == 4) ? {12'h0, wa4[3]} : 32'hxxxxxxxx, 32'd3);
        chk("t4_full", full4, 1'b1);
        chk("t4_final", final_addr4, 20'd4);
        chk("t4_rec", rec4, 1'b0);
        chk("t4_main_idle", wa.size(), 0);
        pulse_start4();
        chk("t4_full_cleared", {full4, rec4}, 2'b01);
        chk("t4_final_cleared", final_addr4, 20'd0);
        pulse_stop4();

        // stop mid-word: partial word discarded
        clear_q();
        pulse_start();
        frame(16'h0101, 16'h0, -1);
        frame(16'h0202, 16'h0, -1);
        frame(16'h0303, 16'h0, 10);
        chk("t5_nwr", wa.size(), 2);
        chk("t5_final", final_addr, 20'd2);
        chk("t5_rec", rec, 1'b0);

        // stop in the first WRITE cycle: write still completes
        clear_q();
        pulse_start();
        begin
            int n;
            fork
                frame(16'h0BAD, 16'h0, -1);
                begin
                    n = 0;
                    @(negedge i_clk);
                    while (sram_bus.o_sram_data !== 16'h0BAD && n < 2000) begin
                        @(negedge i_clk);
                        n++;
                    end
                    i_stop = 1;
                    @(negedge i_clk);
                    i_stop = 0;
                end
            join
            chk("t5b_write_seen", (n < 2000), 1'b1);
        end
        chk("t5b_nwr", wa.size(), 1);
        chk("t5b_data", qd(0), 32'h0BAD);
        chk("t5b_we_len", ql(0), 32'd2);
        chk("t5b_final", final_addr, 20'd1);
        chk("t5b_rec", rec, 1'b0);

        // reset during a write
        clear_q();
        pulse_start();
        frame(16'h0C01, 16'h0, -1);
        begin
            int n;
            fork
                frame(16'h0C02, 16'h0, -1);
                begin
                    n = 0;
                    @(negedge i_clk);
                    while (sram_bus.o_sram_we_n !== 1'b0 && n < 2000) begin
                        @(negedge i_clk);
                        n++;
                    end
                    chk("t6_in_write", {sram_bus.o_sram_we_n, 12'h0, sram_bus.o_sram_addr}, 33'd1);
                    #2 i_rst_n = 0;
                    #1;
                    chk("t6_we_n", sram_bus.o_sram_we_n, 1'b1);
                    chk("t6_addr", sram_bus.o_sram_addr, 20'd0);
                    chk("t6_data", sram_bus.o_sram_data, 16'd0);
                    chk("t6_final", final_addr, 20'd0);
                    chk("t6_rec_full", {rec, full}, 2'b00);
                    @(negedge i_clk);
                    i_rst_n = 1;
                end
            join
        end
        clear_q();
        pulse_start();
        frame(16'h1234, 16'h0, -1);
        chk("t6_post_addr", qa(0), 32'd0);
        chk("t6_post_data", qd(0), 32'h1234);
        chk("t6_post_final", final_addr, 20'd1);
        pulse_stop();

        chk("bus_stable_while_low", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
